// File: rtl/restoring_div.sv
// Unsigned sequential restoring divider: 2W-bit dividend / W-bit divisor,
// operands loaded over a W-bit bus in three beats, one quotient bit per clock.
//
// state  | meaning
// IDLE   | ready, waiting for start; captures dividend high half
// LD_LO  | capture dividend low half
// LD_DIV | capture divisor; divide-by-zero short-cuts to DONE
// ITER   | one shift/trial-subtract step per clock, 2W steps
// DONE   | one-cycle done pulse, results valid
module restoring_div #(
  parameter int W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   inbus,
  input  logic           start,
  output logic           ready,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*W+1);

  typedef enum logic [2:0] {
    IDLE,
    LD_LO,
    LD_DIV,
    ITER,
    DONE
  } state_t;

  state_t         state;
  logic [2*W-1:0] quo;
  logic [W:0]     prem;
  logic [W-1:0]   divisor;
  logic [CW-1:0]  cnt;

  logic [W:0]     shifted;
  logic [W+1:0]   trial;
  logic           q_bit;
  logic [W:0]     prem_next;
  logic [2*W-1:0] quo_next;

  // Partial remainder stays below the divisor, so the shifted value is below
  // 2*divisor and fits W+1 bits; the extra MSB of trial is the borrow.
  always_comb begin
    shifted   = {prem[W-1:0], quo[2*W-1]};
    trial     = {1'b0, shifted} - {2'b00, divisor};
    q_bit     = ~trial[W+1];
    prem_next = q_bit ? trial[W:0] : shifted;
    quo_next  = {quo[2*W-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      quo         <= '0;
      prem        <= '0;
      divisor     <= '0;
      cnt         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            quo[2*W-1:W] <= inbus;
            div_by_zero  <= 1'b0;
            ready        <= 1'b0;
            state        <= LD_LO;
          end
        end
        LD_LO: begin
          quo[W-1:0] <= inbus;
          state      <= LD_DIV;
        end
        LD_DIV: begin
          divisor <= inbus;
          if (inbus == '0) begin
            result      <= '1;
            remainder   <= '1;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            prem  <= '0;
            cnt   <= CW'(2*W);
            state <= ITER;
          end
        end
        ITER: begin
          prem <= prem_next;
          quo  <= quo_next;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result    <= quo_next;
            remainder <= prem_next[W-1:0];
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div.sv
// Self-checking bench for restoring_div: directed and random divides against
// a plain-arithmetic model, plus start-handling and mid-operation reset.
module tb_restoring_div;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   inbus = '0;
  logic           start = 1'b0;
  logic           ready;
  logic           done;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           div_by_zero;

  int checks = 0;
  int errors = 0;

  restoring_div #(.W(W)) dut (
    .clk(clk), .rst(rst), .inbus(inbus), .start(start), .ready(ready),
    .done(done), .result(result), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [W-1:0] dv,
                       output logic [2*W-1:0] q, output logic [W-1:0] r, output logic z);
    int unsigned n;
    n = hi * 32 + lo;
    if (dv == 0) begin
      q = 10'h3FF; r = 5'h1F; z = 1'b1;
    end else begin
      q = 10'(n / dv); r = 5'(n % dv); z = 1'b0;
    end
  endtask

  // Full transaction starting from idle; optional start pulse during ITER.
  task automatic run_div(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [W-1:0] dv,
                         input bit poke, input string name);
    logic [2*W-1:0] eq;
    logic [W-1:0]   er;
    logic           ez;
    int             lat;
    model(hi, lo, dv, eq, er, ez);
    lat = (dv == 0) ? 0 : 10;
    @(negedge clk); inbus = hi; start = 1'b1;
    @(posedge clk);                               // E0
    @(negedge clk); start = 1'b0; inbus = lo;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL %s ready_after_e0 got=%b exp=0", name, ready); end
    @(posedge clk);                               // E1
    @(negedge clk); inbus = dv;
    @(posedge clk);                               // E2
    for (int e = 0; e <= lat; e++) begin
      if (e > 0) @(posedge clk);
      #1;
      if (poke && e == 3) begin start = 1'b1; inbus = 5'h1F; end
      if (poke && e == 4) start = 1'b0;
      checks++;
      if (done !== (e == lat)) begin
        errors++; $display("FAIL %s done_edge%0d got=%b exp=%b", name, e, done, (e == lat));
      end
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL %s ready_busy%0d got=%b exp=0", name, e, ready); end
    end
    checks += 3;
    if (result !== eq) begin errors++; $display("FAIL %s result got=%0d exp=%0d", name, result, eq); end
    if (remainder !== er) begin errors++; $display("FAIL %s remainder got=%0d exp=%0d", name, remainder, er); end
    if (div_by_zero !== ez) begin errors++; $display("FAIL %s dbz got=%b exp=%b", name, div_by_zero, ez); end
    @(posedge clk); #1;
    checks += 4;
    if (ready !== 1'b1) begin errors++; $display("FAIL %s ready_after got=%b exp=1", name, ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_after got=%b exp=0", name, done); end
    if (result !== eq) begin errors++; $display("FAIL %s result_hold got=%0d exp=%0d", name, result, eq); end
    if (div_by_zero !== ez) begin errors++; $display("FAIL %s dbz_hold got=%b exp=%b", name, div_by_zero, ez); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks += 5;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset ready got=%b exp=1", ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset done got=%b exp=0", done); end
    if (result !== '0) begin errors++; $display("FAIL reset result got=%0d exp=0", result); end
    if (remainder !== '0) begin errors++; $display("FAIL reset remainder got=%0d exp=0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset dbz got=%b exp=0", div_by_zero); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL idle ready=%b done=%b exp ready=1 done=0", ready, done);
    end
  endtask

  task automatic test_directed();
    run_div(5'd31, 5'd8, 5'd7, 1'b0, "div_1000_7");
    run_div(5'd31, 5'd31, 5'd31, 1'b0, "div_1023_31");
    run_div(5'd0, 5'd5, 5'd9, 1'b0, "div_5_9");
    run_div(5'd31, 5'd31, 5'd1, 1'b0, "div_1023_1");
    run_div(5'd3, 5'd4, 5'd0, 1'b0, "div_100_0");
    run_div(5'd0, 5'd0, 5'd31, 1'b0, "div_0_31");
  endtask

  task automatic test_random();
    logic [W-1:0] hi, lo, dv;
    for (int i = 0; i < 40; i++) begin
      hi = 5'($urandom);
      lo = 5'($urandom);
      dv = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_div(hi, lo, dv, 1'b0, "random");
    end
  endtask

  task automatic test_start_ignored();
    run_div(5'd31, 5'd8, 5'd7, 1'b1, "start_in_iter");
  endtask

  // start held high throughout: must not be taken on the DONE->IDLE edge.
  task automatic test_back_to_back();
    @(negedge clk); inbus = 5'd31; start = 1'b1;
    @(posedge clk);                               // E0
    @(negedge clk); inbus = 5'd8;
    @(posedge clk);
    @(negedge clk); inbus = 5'd7;
    @(posedge clk);                               // E2
    @(negedge clk); inbus = 5'd0;
    repeat (10) @(posedge clk);                   // E12
    #1;
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b done got=%b exp=1", done); end
    if (result !== 10'd142) begin errors++; $display("FAIL b2b result got=%0d exp=142", result); end
    @(posedge clk); #1;                           // E13
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL b2b ready_e13 got=%b exp=1", ready); end
    @(posedge clk); #1;                           // E14 accepts hi=0
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL b2b accept_e14 got=%b exp=0", ready); end
    start = 1'b0; inbus = 5'd5;
    @(posedge clk);
    @(negedge clk); inbus = 5'd9;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b done2 got=%b exp=1", done); end
    if (result !== 10'd0) begin errors++; $display("FAIL b2b result2 got=%0d exp=0", result); end
    if (remainder !== 5'd5) begin errors++; $display("FAIL b2b rem2 got=%0d exp=5", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit saw_done;
    @(negedge clk); inbus = 5'd31; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; inbus = 5'd8;
    @(posedge clk);
    @(negedge clk); inbus = 5'd7;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks += 5;
    if (ready !== 1'b1) begin errors++; $display("FAIL midrst ready got=%b exp=1", ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL midrst done got=%b exp=0", done); end
    if (result !== '0) begin errors++; $display("FAIL midrst result got=%0d exp=0", result); end
    if (remainder !== '0) begin errors++; $display("FAIL midrst remainder got=%0d exp=0", remainder); end
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst dbz got=%b exp=0", div_by_zero); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL midrst stray_done got=1 exp=0"); end
    run_div(5'd31, 5'd8, 5'd7, 1'b0, "after_reset_1000_7");
  endtask

  initial begin
    #3;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/restoring_div.md
Name: restoring_div

Overview:
Unsigned sequential restoring divider. It is the inverse-operation companion to the team's shift-add multiplier and sits beside it on the same 5-bit operand bus with the same start/ready/done handshake. A 2W-bit dividend and a W-bit divisor are loaded over inbus in three beats. The block then iterates one quotient bit per clock and presents the quotient and remainder.

Parameters:
W, 5, operand bus width and divisor width; the dividend and quotient are 2W bits, the remainder is W bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
inbus  input  W  operand bus: dividend high half, then dividend low half, then divisor
start  input  1  request; sampled only while ready=1
ready  output  1  high while idle and able to accept start
done  output  1  one-cycle pulse when results are valid
result  output  2W  quotient
remainder  output  W  remainder
div_by_zero  output  1  set when the divisor loaded was 0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, done=0, result=0, remainder=0, div_by_zero=0, iteration counter=0.
- Reset is honoured in any state, including mid-iteration. The operation is abandoned and no done pulse is produced.
- States: IDLE, LD_LO, LD_DIV, ITER, DONE. Edges below are counted from E0, the edge that samples start=1 in IDLE.
- IDLE, ready=1:
  - On start=1: capture inbus as dividend[2W-1:W], clear div_by_zero, go to LD_LO (E0).
  - start=0 holds IDLE.
- LD_LO, ready=0: capture inbus as dividend[W-1:0] (E1), go to LD_DIV.
- LD_DIV: capture inbus as divisor (E2).
  - Divisor==0: result=all ones, remainder=all ones, div_by_zero=1, go to DONE.
  - Otherwise: clear the partial remainder (W+1 bits), load the quotient/dividend shift register, load counter=2W, go to ITER.
- ITER, 2W clocks, E3..E(2+2W):
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the zero-extended divisor from the partial remainder.
  - If the trial is non-negative: keep the difference, shift quotient bit 1 in. Otherwise: restore (keep the shifted value), shift 0 in.
  - Decrement the counter. After the iteration at which the counter reaches 0, go to DONE.
- DONE: done=1 for exactly this one cycle, with result, remainder and div_by_zero valid. Next edge goes to IDLE with ready=1.
- Latency, W=5:
  - Normal divide: done is high between E12 and E13, and ready returns at E13.
  - Divide by zero: done is high between E2 and E3.
- result, remainder and div_by_zero are held stable after DONE until the next accepted start, which clears div_by_zero.
- result and remainder may update during iteration, but they are defined only while done=1 or when idle after done.
- start while ready=0 is ignored. No queueing and no restart.
- start=1 on the same edge that DONE returns to IDLE is not accepted. Acceptance requires the state to already be IDLE.
- Arithmetic: all unsigned. The remainder is always less than the divisor (non-zero case) and fits in W bits. The quotient can reach 2W bits (divisor=1).
- inbus is sampled only at E0, E1 and E2. Its value at other times is don't-care.

Test Plan:
- Reset, then idle: ready=1, done=0, result=0, remainder=0, div_by_zero=0.
- Divide 1000 by 7: start with inbus=31, then 8, then 7 -> done at E12, result=142 (0x08E), remainder=6, div_by_zero=0, ready=1 at E13.
- Divide 1023 by 31: inbus=31, 31, 31 -> result=33, remainder=0.
- Divide 5 by 9, dividend smaller than divisor: inbus=0, 5, 9 -> result=0, remainder=5.
- Divide 1023 by 1: inbus=31, 31, 1 -> result=1023, remainder=0.
- Divide 100 by 0: inbus=3, 4, 0 -> done at E2, result=0x3FF, remainder=0x1F, div_by_zero=1.
- Robustness, start handling: pulse start during ITER -> ignored, the original result completes unchanged.
- Robustness, mid-operation reset: assert rst=0 mid-ITER -> outputs at reset values at once and no done pulse. After release, 1000/7 again gives 142 r 6.
